// File: rtl/riscp_pkg.sv
// riscp_pkg: shared opcodes, instruction field positions and fetch FSM state type
// for the pipelined RISC core.
package riscp_pkg;

    localparam logic [5:0] OP_ORI  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b000101;
    localparam logic [5:0] OP_LW   = 6'b000110;
    localparam logic [5:0] OP_BZ   = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b001110;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 22;
    localparam int RS_MSB  = 21;
    localparam int RS_LSB  = 18;
    localparam int RT_MSB  = 17;
    localparam int RT_LSB  = 14;
    localparam int IMM_MSB = 13;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry instruction+pc skid buffer used when a fetch response
// returns while ID is stalled. Clear wins over load, load wins over drain.
module fetch_hold_buf
    import riscp_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic              clear_i,
    input  logic [31:0]       instr_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              valid_o,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc_o
);

    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the payload flops are reset as well; the entry is tiny and a known
    // value keeps the IF/ID fields deterministic whichever path loads them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding instruction fetch and IF/ID register.
// Define FETCH_EARLY_JUMP_EN to retarget the PC on a returning J instruction.
module fetch_stage
    import riscp_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              stall_i,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [31:0]       id_instr,
    output logic [5:0]        id_opcode,
    output logic [3:0]        id_rd,
    output logic [3:0]        id_rs,
    output logic [3:0]        id_rt,
    output logic [13:0]       id_imm14
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              drop_q, drop_d;
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [31:0]       id_instr_q, id_instr_d;

    logic              hb_load, hb_drain, hb_clear, hb_valid;
    logic [31:0]       hb_instr;
    logic [ADDR_W-1:0] hb_pc;
    logic              id_free;

    fetch_hold_buf #(.ADDR_W(ADDR_W)) u_hold_buf (
        .clk     (clk),
        .reset   (reset),
        .load_i  (hb_load),
        .drain_i (hb_drain),
        .clear_i (hb_clear),
        .instr_i (imem_rsp_data),
        .pc_i    (inflight_pc_q),
        .valid_o (hb_valid),
        .instr_o (hb_instr),
        .pc_o    (hb_pc)
    );

    assign id_free        = !id_valid_q || !stall_i;
    assign imem_req_valid = (state_q == S_REQ) && !redirect_valid;
    assign imem_req_addr  = pc_q;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        drop_d        = drop_q;
        id_valid_d    = stall_i ? id_valid_q : 1'b0;
        id_pc_d       = id_pc_q;
        id_instr_d    = id_instr_q;
        hb_load       = 1'b0;
        hb_drain      = 1'b0;
        hb_clear      = 1'b0;

        if (redirect_valid) begin
            // Redirect beats stall; an in-flight fetch is marked for discard.
            pc_d       = redirect_pc;
            id_valid_d = 1'b0;
            hb_clear   = 1'b1;
            case (state_q)
                S_WAIT: begin
                    drop_d  = !imem_rsp_valid;
                    state_d = imem_rsp_valid ? S_REQ : S_WAIT;
                end
                S_HOLD: begin
                    drop_d  = 1'b0;
                    state_d = S_REQ;
                end
                default: ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_req_ready) begin
                        inflight_pc_d = pc_q;
                        pc_d          = pc_q + ADDR_W'(1);
                        state_d       = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
`ifdef FETCH_EARLY_JUMP_EN
                            if (imem_rsp_data[OPC_MSB:OPC_LSB] == OP_J) begin
                                pc_d = inflight_pc_q
                                     + {{(ADDR_W-IMM_W){imem_rsp_data[IMM_MSB]}},
                                        imem_rsp_data[IMM_MSB:IMM_LSB]};
                            end
`endif
                            if (id_free) begin
                                id_valid_d = 1'b1;
                                id_pc_d    = inflight_pc_q;
                                id_instr_d = imem_rsp_data;
                                state_d    = S_REQ;
                            end else begin
                                hb_load = 1'b1;
                                state_d = S_HOLD;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        id_valid_d = hb_valid;
                        id_pc_d    = hb_pc;
                        id_instr_d = hb_instr;
                        hb_drain   = 1'b1;
                        state_d    = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            drop_q        <= 1'b0;
            id_valid_q    <= 1'b0;
            id_pc_q       <= '0;
            id_instr_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            drop_q        <= drop_d;
            id_valid_q    <= id_valid_d;
            id_pc_q       <= id_pc_d;
            id_instr_q    <= id_instr_d;
        end
    end

    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_instr  = id_instr_q;
    assign id_opcode = id_instr_q[OPC_MSB:OPC_LSB];
    assign id_rd     = id_instr_q[RD_MSB:RD_LSB];
    assign id_rs     = id_instr_q[RS_MSB:RS_LSB];
    assign id_rt     = id_instr_q[RT_MSB:RT_LSB];
    assign id_imm14  = id_instr_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized fetch traffic, checked against
// an instruction-stream model (program order, redirects, stall holding).
module tb_fetch_stage;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_EARLY_JUMP_EN
    localparam bit          EARLY_JUMP = 1'b1;
    localparam logic [31:0] JUMP_NEXT  = 32'h10;
`else
    localparam bit          EARLY_JUMP = 1'b0;
    localparam logic [31:0] JUMP_NEXT  = 32'h21;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        stall_i = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [5:0]  id_opcode;
    logic [3:0]  id_rd, id_rs, id_rt;
    logic [13:0] id_imm14;

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall_i        (stall_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_opcode      (id_opcode),
        .id_rd          (id_rd),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_imm14       (id_imm14)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents: two pinned words, the rest a hash of the address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        if (a == 32'h0)  return 32'h1400_1234;
        if (a == 32'h20) return 32'h3800_3FF0;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] instr);
        logic [31:0] ofs;
        ofs = {{18{instr[13]}}, instr[13:0]};
        if (EARLY_JUMP && instr[31:26] == 6'b001110) return pc + ofs;
        return pc + 32'd1;
    endfunction

    // Model state: expected next delivered PC, memory outstanding slot, last-cycle record.
    logic [31:0] exp_pc;
    bit          mem_out;
    logic [31:0] out_addr;
    int          rsp_wait;
    int          force_wait;
    bit          spur_en, spur_force;
    int          idle;
    bit          p_ok, p_hs, p_stall, p_redir, p_rdy, p_req_valid, p_id_valid;
    logic [31:0] p_addr, p_rpc, p_id_pc, p_id_instr;

    task automatic reset_model();
        exp_pc   = RESET_PC;
        mem_out  = 1'b0;
        out_addr = '0;
        rsp_wait = 0;
        idle     = 0;
        p_ok     = 1'b0;
    endtask

    // One clock cycle: check registered outputs against the model, drive inputs,
    // then check request-side rules and record this cycle for the next one.
    task automatic step(input logic stall, input logic redir, input logic [31:0] rpc,
                        input logic rdy);
        logic [31:0] ei;
        bit          out_start;
        @(negedge clk);
        if (p_ok && p_hs) begin
            mem_out  = 1'b1;
            out_addr = p_addr;
            rsp_wait = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 2));
        end
        if (p_ok) begin
            if (p_redir) begin
                check("redirect_flush_valid", id_valid, 1'b0);
                exp_pc = p_rpc;
            end else if (p_id_valid && p_stall) begin
                check("stall_hold_valid", id_valid, 1'b1);
                check("stall_hold_pc", id_pc, p_id_pc);
                check("stall_hold_instr", id_instr, p_id_instr);
            end else if (id_valid) begin
                ei = instr_of(exp_pc);
                check("deliver_pc", id_pc, exp_pc);
                check("deliver_instr", id_instr, ei);
                check("deliver_opcode", id_opcode, ei[31:26]);
                check("deliver_rd", id_rd, ei[25:22]);
                check("deliver_rs", id_rs, ei[21:18]);
                check("deliver_rt", id_rt, ei[17:14]);
                check("deliver_imm14", id_imm14, ei[13:0]);
                exp_pc = next_pc(exp_pc, ei);
                idle   = 0;
            end else begin
                check("bubble_keeps_pc", id_pc, p_id_pc);
            end
        end
        idle++;

        out_start      = mem_out;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (mem_out) begin
            if (rsp_wait == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instr_of(out_addr);
                mem_out        = 1'b0;
            end else begin
                rsp_wait--;
            end
        end else if (spur_force || (spur_en && $urandom_range(0, 9) == 0)) begin
            imem_rsp_valid = 1'b1;
        end
        stall_i        = stall;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        #1;
        if (out_start) check("single_outstanding", imem_req_valid, 1'b0);
        if (redir) check("no_req_during_redirect", imem_req_valid, 1'b0);
        if (p_ok && p_req_valid && !p_rdy && !p_redir && !redir) begin
            check("req_stable_valid", imem_req_valid, 1'b1);
            check("req_stable_addr", imem_req_addr, p_addr);
        end

        p_ok        = 1'b1;
        p_hs        = imem_req_valid && rdy;
        p_addr      = imem_req_addr;
        p_req_valid = imem_req_valid;
        p_rdy       = rdy;
        p_stall     = stall;
        p_redir     = redir;
        p_rpc       = rpc;
        p_id_valid  = id_valid;
        p_id_pc     = id_pc;
        p_id_instr  = id_instr;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        bit found;
        force_wait = 0;
        spur_en    = 1'b0;
        spur_force = 1'b0;
        reset_model();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_id_valid", id_valid, 1'b0);
        check("reset_id_pc", id_pc, 32'h0);
        check("reset_id_instr", id_instr, 32'h0);
        check("reset_req_addr", imem_req_addr, RESET_PC);
        @(posedge clk);
        #2 reset = 1'b0;

        // Basic latency: request at cycle 0, ID valid at cycle 2.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("c0_req_valid", imem_req_valid, 1'b1);
        check("c0_req_addr", imem_req_addr, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("c1_id_valid", id_valid, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("c2_id_valid", id_valid, 1'b1);
        check("c2_id_opcode", id_opcode, 6'b000101);
        check("c2_id_imm14", id_imm14, 14'h1234);
        check("c2_id_pc", id_pc, 32'h0);
        check("c2_req_valid", imem_req_valid, 1'b1);
        check("c2_req_addr", imem_req_addr, 32'h1);

        // Stall while the response for addr 1 returns: goes to the hold buffer.
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("hold_no_req", imem_req_valid, 1'b0);
        check("hold_id_pc", id_pc, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("hold_still_no_req", imem_req_valid, 1'b0);
        check("hold_id_valid", id_valid, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("drain_id_valid", id_valid, 1'b1);
        check("drain_id_pc", id_pc, 32'h1);
        check("drain_req_addr", imem_req_addr, 32'h2);

        // Redirect while waiting: in-flight response for addr 2 is dropped.
        force_wait = 1;
        step(1'b0, 1'b1, 32'h40, 1'b1);
        force_wait = 0;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("redir_id_valid", id_valid, 1'b0);
        check("redir_wait_no_req", imem_req_valid, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("redir_req_valid", imem_req_valid, 1'b1);
        check("redir_req_addr", imem_req_addr, 32'h40);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Ready held low five cycles: request parked at 0x41, ID drains.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            check("notready_req_valid", imem_req_valid, 1'b1);
            check("notready_req_addr", imem_req_addr, 32'h41);
            if (i == 0) check("redir_first_id_pc", id_pc, 32'h40);
            if (i == 2) check("notready_id_drained", id_valid, 1'b0);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("ready_id_pc", id_pc, 32'h41);

        // Reset while waiting on the response for 0x42.
        force_wait = 1;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        reset = 1'b1;
        #1;
        check("midreset_id_valid", id_valid, 1'b0);
        check("midreset_id_pc", id_pc, 32'h0);
        check("midreset_id_instr", id_instr, 32'h0);
        check("midreset_req_addr", imem_req_addr, RESET_PC);
        reset_model();
        force_wait = 0;
        @(posedge clk);
        #2 reset = 1'b0;
        spur_force = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        spur_force = 1'b0;
        check("postreset_req_valid", imem_req_valid, 1'b1);
        check("postreset_req_addr", imem_req_addr, RESET_PC);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("postreset_id_pc", id_pc, RESET_PC);
        check("postreset_id_instr", id_instr, 32'h1400_1234);

        // J at 0x20 with imm14 = -16.
        step(1'b0, 1'b1, 32'h20, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (imem_req_valid && imem_req_addr == 32'h20) found = 1'b1;
        end
        check("jump_fetch_seen", found, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (imem_req_valid) found = 1'b1;
        end
        check("jump_next_req_seen", found, 1'b1);
        check("jump_next_req_addr", imem_req_addr, JUMP_NEXT);

        // Randomized traffic: stalls, redirects (incl. near wrap), ready gaps,
        // variable latency and stray responses.
        spur_en    = 1'b1;
        force_wait = -1;
        for (int i = 0; i < 3000; i++) begin
            logic        st, rd, rdy;
            logic [31:0] rpc;
            st  = ($urandom_range(0, 99) < 30);
            rd  = ($urandom_range(0, 99) < 4);
            rdy = ($urandom_range(0, 99) < 75);
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 1023));
            step(st, rd, rpc, rdy);
            if (idle > 200) begin
                check("fetch_progress_idle_cycles", idle, 0);
                idle = 0;
            end
        end
        spur_en = 1'b0;
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
